// File: rtl/fg_pkg.sv
// Shared types and constants for the DDS waveform generator.
package fg_pkg;

  localparam int unsigned FG_LAT = 2;

  typedef enum logic [1:0] {
    FG_MODE_CONST  = 2'd0,
    FG_MODE_SQUARE = 2'd1,
    FG_MODE_SAW    = 2'd2,
    FG_MODE_TRI    = 2'd3
  } fg_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fg_state_e;

  typedef struct packed {
    fg_mode_e   mode;
    logic       radix;
    logic [7:0] burst;
  } fg_ctrl_t;

endpackage

// File: rtl/fg_prescaler.sv
// Tick generator: one tick every reload_i+1 enabled cycles.
module fg_prescaler #(
  parameter int unsigned PSC_W = 9
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clear_i,
  input  logic [PSC_W-1:0] reload_i,
  output logic             tick_o
);

  logic [PSC_W-1:0] cnt_q;

  assign tick_o = en_i && (cnt_q == reload_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= tick_o ? '0 : cnt_q + PSC_W'(1);
    end
  end

endmodule

// File: rtl/fg_dds_wavegen.sv
// Phase-accumulator waveform generator with shadowed config applied at period wrap.
// Optional burst mode (period count, DONE state) enabled by defining FG_BURST_EN.
module fg_dds_wavegen
  import fg_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned PHASE_W = 16,
  parameter int unsigned PSC_W   = 9
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               enable_i,
  input  logic               cfg_valid_i,
  output logic               cfg_ready_o,
  input  logic [1:0]         cfg_mode_i,
  input  logic               cfg_radix_i,
  input  logic [PSC_W-1:0]   cfg_psc_i,
  input  logic [PHASE_W-1:0] cfg_inc_i,
  input  logic [PHASE_W-1:0] cfg_duty_i,
  input  logic [DATA_W-1:0]  cfg_amp_i,
  input  logic [DATA_W-1:0]  cfg_offset_i,
  input  logic [7:0]         cfg_burst_i,
  output logic [DATA_W-1:0]  out_o,
  output logic               out_valid_o,
  output logic               wrap_o,
  output logic               burst_done_o
);

  localparam logic signed [DATA_W:0]     SQ_HI = (DATA_W+1)'((1 << (DATA_W-1)) - 1);
  localparam logic signed [DATA_W:0]     MID   = (DATA_W+1)'(1 << (DATA_W-1));
  localparam logic signed [2*DATA_W+1:0] Y_MAX = (2*DATA_W+2)'((1 << (DATA_W-1)) - 1);
  localparam logic signed [2*DATA_W+1:0] Y_MIN = ~Y_MAX;

  fg_state_e state_q, state_d;

  fg_ctrl_t                   sh_ctrl_q, act_ctrl_q;
  logic [PSC_W-1:0]           sh_psc_q, act_psc_q;
  logic [PHASE_W-1:0]         sh_inc_q, act_inc_q, sh_duty_q, act_duty_q;
  logic [DATA_W-1:0]          sh_amp_q, act_amp_q, sh_off_q, act_off_q;
  logic                       pending_q, has_cfg_q;

  logic                       accept, apply, tick, wrap_tick, burst_hit, flush;
  logic [PHASE_W-1:0]         phase_q;
  logic [PHASE_W:0]           phase_sum;

  logic [DATA_W-1:0]          p, q;
  logic signed [DATA_W:0]     raw_d, raw_q;
  logic [DATA_W-1:0]          s1_amp_q, s1_off_q;
  logic                       s1_radix_q;
  logic [FG_LAT-1:0]          vld_q;
  logic signed [2*DATA_W+1:0] prod, prod_sh, y_wide;
  logic [DATA_W-1:0]          y_sat, y_out;

  assign cfg_ready_o = !pending_q;
  assign accept      = cfg_valid_i && cfg_ready_o;
  assign phase_sum   = {1'b0, phase_q} + {1'b0, act_inc_q};
  assign wrap_tick   = tick && phase_sum[PHASE_W];
  // In RUN the shadow waits for the wrapping tick; elsewhere it lands the cycle after accept.
  assign apply       = pending_q && ((state_q == ST_RUN) ? wrap_tick : 1'b1);
  assign flush       = (state_d == ST_IDLE);
  assign out_valid_o = vld_q[FG_LAT-1];

  fg_prescaler #(.PSC_W(PSC_W)) u_psc (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .en_i     (state_q == ST_RUN),
    .clear_i  (apply || (state_q != ST_RUN)),
    .reload_i (act_psc_q),
    .tick_o   (tick)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending_q  <= 1'b0;
      has_cfg_q  <= 1'b0;
      sh_ctrl_q  <= '0;
      sh_psc_q   <= '0;
      sh_inc_q   <= '0;
      sh_duty_q  <= '0;
      sh_amp_q   <= '0;
      sh_off_q   <= '0;
      act_ctrl_q <= '0;
      act_psc_q  <= '0;
      act_inc_q  <= '0;
      act_duty_q <= '0;
      act_amp_q  <= '0;
      act_off_q  <= '0;
    end else begin
      if (accept) begin
        pending_q <= 1'b1;
        sh_ctrl_q <= '{mode: fg_mode_e'(cfg_mode_i), radix: cfg_radix_i, burst: cfg_burst_i};
        sh_psc_q  <= cfg_psc_i;
        sh_inc_q  <= cfg_inc_i;
        sh_duty_q <= cfg_duty_i;
        sh_amp_q  <= cfg_amp_i;
        sh_off_q  <= cfg_offset_i;
      end
      if (apply) begin
        pending_q  <= 1'b0;
        has_cfg_q  <= 1'b1;
        act_ctrl_q <= sh_ctrl_q;
        act_psc_q  <= sh_psc_q;
        act_inc_q  <= sh_inc_q;
        act_duty_q <= sh_duty_q;
        act_amp_q  <= sh_amp_q;
        act_off_q  <= sh_off_q;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      wrap_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      wrap_o  <= wrap_tick;
      if (apply || (state_q == ST_IDLE)) begin
        phase_q <= '0;
      end else if (tick) begin
        phase_q <= phase_sum[PHASE_W-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (enable_i && has_cfg_q) state_d = ST_RUN;
      ST_RUN:  if (!enable_i) state_d = ST_IDLE;
               else if (burst_hit) state_d = ST_DONE;
      ST_DONE: if (!enable_i) state_d = ST_IDLE;
               else if (apply) state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef FG_BURST_EN
  logic [7:0] burst_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      burst_cnt_q <= '0;
    end else if (apply || (state_q == ST_IDLE)) begin
      burst_cnt_q <= '0;
    end else if (wrap_tick) begin
      burst_cnt_q <= burst_cnt_q + 8'd1;
    end
  end

  // A wrap that installs a new config restarts the count instead of finishing.
  assign burst_hit    = wrap_tick && !apply && (act_ctrl_q.burst != 8'd0) &&
                        (burst_cnt_q + 8'd1 == act_ctrl_q.burst);
  assign burst_done_o = (state_q == ST_DONE);
`else
  logic burst_unused;
  assign burst_unused = ^act_ctrl_q.burst;
  assign burst_hit    = 1'b0;
  assign burst_done_o = 1'b0;
`endif

  always_comb begin
    p     = phase_q[PHASE_W-1 -: DATA_W];
    q     = phase_q[PHASE_W-2 -: DATA_W] ^ {DATA_W{phase_q[PHASE_W-1]}};
    raw_d = '0;
    case (act_ctrl_q.mode)
      FG_MODE_SQUARE: raw_d = (phase_q < act_duty_q) ? SQ_HI : -SQ_HI;
      FG_MODE_SAW:    raw_d = $signed({1'b0, p}) - MID;
      FG_MODE_TRI:    raw_d = $signed({1'b0, q}) - MID;
      default:        raw_d = '0;
    endcase
  end

  always_comb begin
    prod    = $signed({{(DATA_W+1){raw_q[DATA_W]}}, raw_q}) *
              $signed({{(DATA_W+1){1'b0}}, s1_amp_q});
    prod_sh = prod >>> DATA_W;
    y_wide  = prod_sh + $signed({{(DATA_W+2){s1_off_q[DATA_W-1]}}, s1_off_q});
    if (y_wide > Y_MAX)      y_sat = Y_MAX[DATA_W-1:0];
    else if (y_wide < Y_MIN) y_sat = Y_MIN[DATA_W-1:0];
    else                     y_sat = y_wide[DATA_W-1:0];
    y_out = s1_radix_q ? {~y_sat[DATA_W-1], y_sat[DATA_W-2:0]} : y_sat;
  end

  // Gain/offset/radix travel with the sample so a wrap-time apply cannot alter in-flight data.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q      <= '0;
      raw_q      <= '0;
      s1_amp_q   <= '0;
      s1_off_q   <= '0;
      s1_radix_q <= 1'b0;
      out_o      <= '0;
    end else if (flush) begin
      vld_q <= '0;
      out_o <= '0;
    end else begin
      vld_q <= {vld_q[FG_LAT-2:0], tick};
      if (tick) begin
        raw_q      <= raw_d;
        s1_amp_q   <= act_amp_q;
        s1_off_q   <= act_off_q;
        s1_radix_q <= act_ctrl_q.radix;
      end
      if (vld_q[0]) out_o <= y_out;
    end
  end

endmodule

// File: tb/tb_fg_dds_wavegen.sv
// Directed self-checking bench for fg_dds_wavegen (DATA_W=8, PHASE_W=16).
module tb_fg_dds_wavegen;
  import fg_pkg::*;

  logic        clk = 1'b0, rst = 1'b1, enable = 1'b0, cfg_valid = 1'b0, cfg_ready;
  logic [1:0]  cfg_mode = '0;
  logic        cfg_radix = 1'b0;
  logic [8:0]  cfg_psc = '0;
  logic [15:0] cfg_inc = '0, cfg_duty = '0;
  logic [7:0]  cfg_amp = '0, cfg_offset = '0, cfg_burst = '0;
  logic [7:0]  out;
  logic        out_valid, wrap, burst_done;

  int checks = 0, errors = 0;

  fg_dds_wavegen #(.DATA_W(8), .PHASE_W(16), .PSC_W(9)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .enable_i     (enable),
    .cfg_valid_i  (cfg_valid),
    .cfg_ready_o  (cfg_ready),
    .cfg_mode_i   (cfg_mode),
    .cfg_radix_i  (cfg_radix),
    .cfg_psc_i    (cfg_psc),
    .cfg_inc_i    (cfg_inc),
    .cfg_duty_i   (cfg_duty),
    .cfg_amp_i    (cfg_amp),
    .cfg_offset_i (cfg_offset),
    .cfg_burst_i  (cfg_burst),
    .out_o        (out),
    .out_valid_o  (out_valid),
    .wrap_o       (wrap),
    .burst_done_o (burst_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_cfg(input logic [1:0] mode, input logic radix, input logic [8:0] psc,
                         input logic [15:0] inc, input logic [15:0] duty,
                         input logic [7:0] amp, input logic [7:0] off, input logic [7:0] burst);
    cfg_mode = mode; cfg_radix = radix; cfg_psc = psc; cfg_inc = inc;
    cfg_duty = duty; cfg_amp = amp; cfg_offset = off; cfg_burst = burst;
  endtask

  // Called at a negedge while idle; applies within two cycles.
  task automatic load_cfg(input logic [1:0] mode, input logic radix, input logic [8:0] psc,
                          input logic [15:0] inc, input logic [15:0] duty,
                          input logic [7:0] amp, input logic [7:0] off, input logic [7:0] burst);
    set_cfg(mode, radix, psc, inc, duty, amp, off, burst);
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    check("ready_low_after_accept", 32'(cfg_ready), 'h0);
    repeat (2) @(negedge clk);
    check("ready_after_load", 32'(cfg_ready), 'h1);
  endtask

  task automatic start();
    enable = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic stop(input string tag);
    enable = 1'b0;
    @(negedge clk);
    check({tag, "_idle_out"}, 32'(out), 'h0);
    check({tag, "_idle_valid"}, 32'(out_valid), 'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int vcount, w1, w2, wn, v1, v2;

    repeat (2) @(negedge clk);
    check("rst_out", 32'(out), 'h0);
    check("rst_valid", 32'(out_valid), 'h0);
    check("rst_wrap", 32'(wrap), 'h0);
    check("rst_ready", 32'(cfg_ready), 'h1);
    check("rst_burst_done", 32'(burst_done), 'h0);
    rst = 1'b0;
    @(negedge clk);

    // Sawtooth, full gain: -128 .. 126 over 256 samples
    load_cfg(2'd2, 1'b0, 9'd0, 16'h0100, 16'h0000, 8'd255, 8'h00, 8'd0);
    start();
    vcount = 0; w1 = -1; w2 = -1; wn = 0;
    for (int k = 0; k < 516; k++) begin
      @(negedge clk);
      if (out_valid) vcount++;
      if (wrap) begin
        wn++;
        if (w1 < 0) w1 = k; else if (w2 < 0) w2 = k;
      end
      if (k == 0)   check("saw_first", 32'(out), 'h80);
      if (k == 1)   check("saw_second", 32'(out), 'h81);
      if (k == 128) check("saw_mid", 32'(out), 'h00);
      if (k == 255) check("saw_last", 32'(out), 'h7E);
      if (k == 256) check("saw_repeat", 32'(out), 'h80);
    end
    check("saw_valid_count", 32'(vcount), 'd516);
    check("saw_wrap_count", 32'(wn), 'd2);
    check("saw_wrap_first", 32'(w1), 'd254);
    check("saw_wrap_period", 32'(w2 - w1), 'd256);
    stop("saw");

    // Square with saturating offset, then a config swap accepted mid-period
    load_cfg(2'd1, 1'b0, 9'd0, 16'h1000, 16'h8000, 8'd128, 8'd100, 8'd0);
    start();
    for (int k = 0; k < 34; k++) begin
      @(negedge clk);
      if (k < 16) check($sformatf("sq_s%0d", k), 32'(out), (k < 8) ? 'h7F : 'h24);
      if (k == 18) begin
        set_cfg(2'd2, 1'b0, 9'd0, 16'h1000, 16'h0000, 8'd255, 8'h00, 8'd0);
        cfg_valid = 1'b1;
      end
      if (k == 19) begin
        cfg_valid = 1'b0;
        check("swap_ready_low", 32'(cfg_ready), 'h0);
      end
      if (k == 29) check("swap_ready_hold", 32'(cfg_ready), 'h0);
      if (k == 30) check("swap_ready_back", 32'(cfg_ready), 'h1);
      if (k == 31) check("swap_old_last", 32'(out), 'h24);
      if (k == 32) check("swap_new_first", 32'(out), 'h80);
      if (k == 33) check("swap_new_second", 32'(out), 'h90);
    end
    check("no_burst_done", 32'(burst_done), 'h0);
    stop("sq");

    // Constant, offset-binary output
    load_cfg(2'd0, 1'b1, 9'd0, 16'h0000, 16'h0000, 8'd255, 8'h80, 8'd0);
    start();
    @(negedge clk);
    check("const_neg_full", 32'(out), 'h00);
    check("const_valid", 32'(out_valid), 'h1);
    stop("const");

    load_cfg(2'd0, 1'b1, 9'd3, 16'h0000, 16'h0000, 8'd255, 8'h00, 8'd0);
    start();
    vcount = 0; v1 = -1; v2 = -1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (out_valid) begin
        vcount++;
        if (v1 < 0) v1 = k; else if (v2 < 0) v2 = k;
        check($sformatf("const_zero_k%0d", k), 32'(out), 'h80);
      end
    end
    check("psc_valid_count", 32'(vcount), 'd4);
    check("psc_first_valid", 32'(v1), 'd3);
    check("psc_interval", 32'(v2 - v1), 'd4);

    // Reset while running; enable alone must not restart
    rst = 1'b1;
    #1;
    check("midrst_out", 32'(out), 'h0);
    check("midrst_valid", 32'(out_valid), 'h0);
    check("midrst_ready", 32'(cfg_ready), 'h1);
    @(negedge clk);
    rst = 1'b0;
    vcount = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid) vcount++;
    end
    check("midrst_no_restart", 32'(vcount), 'd0);
    check("midrst_out_hold", 32'(out), 'h0);
    enable = 1'b0;
    @(negedge clk);

`ifdef FG_BURST_EN
    load_cfg(2'd2, 1'b0, 9'd0, 16'h4000, 16'h0000, 8'd255, 8'h00, 8'd3);
    start();
    vcount = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) vcount++;
    end
    check("burst_strobes", 32'(vcount), 'd12);
    check("burst_done", 32'(burst_done), 'h1);
    check("burst_valid_off", 32'(out_valid), 'h0);
    stop("burst");
    check("burst_done_clear", 32'(burst_done), 'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
